sevenseg_ctl: RTL and testbench

SEVENSEG_CTL -- requirements
Module: sevenseg_ctl

---
 rtl/sevenseg_ctl_if.sv | 24 ++
 rtl/sevenseg_ctl.sv | 77 +++++++
 tb/tb_sevenseg_ctl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sevenseg_ctl_if.sv
// Purpose: write port and display outputs of the multiplexed seven-segment scanner.
// Latency: n/a (signal bundle only).
// Backpressure: none; one write per cycle, outputs are free-running.
// Ports: en, wr_en, wr_addr[2:0], wr_data[6:0] (master -> slave);
//        data[6:0], an_n[7:0], frame_tick (slave -> master).
interface sevenseg_ctl_if;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic [6:0] data;
  logic [7:0] an_n;
  logic       frame_tick;

  modport master (
    output en, wr_en, wr_addr, wr_data,
    input  data, an_n, frame_tick
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data,
    output data, an_n, frame_tick
  );
endinterface

// File: rtl/sevenseg_ctl.sv
// Purpose: 8-digit seven-segment scan controller with digit registers and ghosting blank.
// Latency: outputs registered, aligned with the post-edge counter state; writes bypass to data same edge.
// Backpressure: none; a write is accepted every cycle, last write to an address wins.
// Ports: clk, rst_n (async active-low); bus (slave): en, wr_en, wr_addr, wr_data in;
//        data, an_n, frame_tick out.
module sevenseg_ctl #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 4
) (
  input logic          clk,
  input logic          rst_n,
  sevenseg_ctl_if.slave bus
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       digit;
  logic [2:0]       digit_nxt;
  logic             wrap;
  logic             in_blank;
  logic [7:0]       an_sel;
  logic [6:0]       digit_reg [8];
  logic [6:0]       data_q;
  logic [7:0]       an_n_q;
  logic             frame_tick_q;

  assign wrap      = (cnt == CNT_W'(DIV - 1));
  assign cnt_nxt   = wrap ? '0 : cnt + 1'b1;
  assign digit_nxt = wrap ? digit + 3'd1 : digit;

  // The blank window is judged on the post-edge count so an_n lines up with cnt.
  // A zero-length window is split out to avoid a constant-false compare.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_nxt < CNT_W'(BLANK_CYC));
    end
  endgenerate

  assign an_sel = ~(8'h01 << digit_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      digit        <= '0;
      data_q       <= 7'h00;
      an_n_q       <= 8'hFF;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        digit_reg[i] <= 7'h00;
      end
    end else begin
      cnt   <= cnt_nxt;
      digit <= digit_nxt;
      if (bus.wr_en) begin
        digit_reg[bus.wr_addr] <= bus.wr_data;
      end
      // Bypass so a write to the digit being shown appears on the same edge.
      if (bus.wr_en && (bus.wr_addr == digit_nxt)) begin
        data_q <= bus.wr_data;
      end else begin
        data_q <= digit_reg[digit_nxt];
      end
      an_n_q       <= (!bus.en || in_blank) ? 8'hFF : an_sel;
      // Only a 7 -> 0 digit wrap pulses; the reset state (0,0) never does.
      frame_tick_q <= wrap && (digit == 3'd7);
    end
  end

  assign bus.data       = data_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_ctl.sv
// Bench for sevenseg_ctl: two builds (BLANK_CYC=2 and BLANK_CYC=0, DIV=8) driven in lockstep.
// The driver pushes the expected post-edge outputs into a queue; a monitor pops and compares.
module tb_sevenseg_ctl;

  typedef struct {
    logic [6:0] data;
    logic [7:0] an_n;
    logic [7:0] an0;
    logic       tick;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   tick_cnt;
  int   k;
  logic [6:0] m_reg [8];
  exp_t q [$];

  sevenseg_ctl_if ifc ();
  sevenseg_ctl_if ifc0 ();

  sevenseg_ctl #(.DIV(8), .BLANK_CYC(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  sevenseg_ctl #(.DIV(8), .BLANK_CYC(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output cycle that has an expectation queued is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_data", 32'(ifc.data), 32'(e.data));
        chk("sb_an_n", 32'(ifc.an_n), 32'(e.an_n));
        chk("sb_an_n_noblank", 32'(ifc0.an_n), 32'(e.an0));
        chk("sb_tick", 32'(ifc.frame_tick), 32'(e.tick));
        chk("sb_data_noblank", 32'(ifc0.data), 32'(e.data));
        if (ifc.frame_tick === 1'b1) tick_cnt++;
      end
    end
  end

  // Called at a negedge: drive inputs for the coming edge, push what that edge must produce.
  task automatic step(input logic e, input logic we, input logic [2:0] a, input logic [6:0] d);
    exp_t x;
    int   c;
    int   dg;
    logic [7:0] sel;
    ifc.en  = e;  ifc.wr_en  = we;  ifc.wr_addr  = a;  ifc.wr_data  = d;
    ifc0.en = e;  ifc0.wr_en = we;  ifc0.wr_addr = a;  ifc0.wr_data = d;
    k++;
    c  = k % 8;
    dg = (k / 8) % 8;
    if (we) m_reg[a] = d;
    sel    = 8'h01 << dg;
    x.data = m_reg[dg];
    x.an_n = (!e || c < 2) ? 8'hFF : ~sel;
    x.an0  = (!e) ? 8'hFF : ~sel;
    x.tick = (k % 64 == 0);
    q.push_back(x);
    @(posedge clk);
    #2;
    @(negedge clk);
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 8; i++) m_reg[i] = 7'h00;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; tick_cnt = 0;
    rst_n = 1'b0;
    ifc.en  = 1'b0; ifc.wr_en  = 1'b0; ifc.wr_addr  = 3'd0; ifc.wr_data  = 7'h00;
    ifc0.en = 1'b0; ifc0.wr_en = 1'b0; ifc0.wr_addr = 3'd0; ifc0.wr_data = 7'h00;
    model_reset();
    #12;
    chk("rst_data", 32'(ifc.data), 32'h00);
    chk("rst_an_n", 32'(ifc.an_n), 32'hFF);
    chk("rst_tick", 32'(ifc.frame_tick), 32'h0);
    chk("rst_an_n_noblank", 32'(ifc0.an_n), 32'hFF);

    // First slot: write to digit 0 on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    tick_cnt = 0;
    step(1'b1, 1'b1, 3'd0, 7'h41);
    chk("slot0_blank_an", 32'(ifc.an_n), 32'hFF);
    chk("slot0_bypass_data", 32'(ifc.data), 32'h41);
    chk("slot0_noblank_an", 32'(ifc0.an_n), 32'hFE);
    step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("slot0_lit_an", 32'(ifc.an_n), 32'hFE);
    chk("slot0_lit_data", 32'(ifc.data), 32'h41);
    // Fill digits 2..6 ahead of their slots (k = 3..7).
    for (int i = 3; i <= 7; i++) step(1'b1, 1'b1, 3'(i - 1), 7'(7'h40 + i));
    chk("slot0_end_noblank_an", 32'(ifc0.an_n), 32'hFE);
    step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("slot1_start_an", 32'(ifc.an_n), 32'hFF);
    chk("slot1_wrap_noblank_an", 32'(ifc0.an_n), 32'hFD);
    chk("slot1_data", 32'(ifc.data), 32'h00);
    step(1'b1, 1'b0, 3'd0, 7'h00);
    step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("slot1_lit_an", 32'(ifc.an_n), 32'hFD);

    // Free run to 200 edges: pulses at 64, 128, 192.
    while (k < 200) step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("free_run_ticks", 32'(tick_cnt), 32'd3);

    // Display disabled for a full frame.
    tick_cnt = 0;
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 3'd0, 7'h00);
    chk("en_off_ticks", 32'(tick_cnt), 32'd1);

    // Writes during digit 3's slot.
    while (k % 64 != 25) step(1'b1, 1'b0, 3'd0, 7'h00);
    step(1'b1, 1'b1, 3'd3, 7'h6A);
    chk("live_write_data", 32'(ifc.data), 32'h6A);
    step(1'b1, 1'b0, 3'd0, 7'h00);
    step(1'b1, 1'b1, 3'd5, 7'h15);
    chk("other_write_hold", 32'(ifc.data), 32'h6A);
    while (k % 64 != 40) step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("other_write_shown", 32'(ifc.data), 32'h15);

    // Async reset during digit 4, cnt 5.
    while (k % 64 != 37) step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("pre_rst_an", 32'(ifc.an_n), 32'hEF);
    chk("pre_rst_data", 32'(ifc.data), 32'h45);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(ifc.data), 32'h00);
    chk("async_rst_an", 32'(ifc.an_n), 32'hFF);
    chk("async_rst_tick", 32'(ifc.frame_tick), 32'h0);
    chk("async_rst_an_noblank", 32'(ifc0.an_n), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick_cnt = 0;
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("post_rst_ticks", 32'(tick_cnt), 32'd1);
    chk("post_rst_data", 32'(ifc.data), 32'h00);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
